// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: data word, RAM status codes, arbiter
// states and the poison word returned when a RAM access is aborted.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM status as reported by the variable-latency RAM block
  typedef logic [1:0] ramstate_t;
  localparam ramstate_t FREE   = 2'd0;
  localparam ramstate_t BUSY   = 2'd1;
  localparam ramstate_t ACCESS = 2'd2;
  localparam ramstate_t ERROR  = 2'd3;

  // Arbiter sequencing states
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t IGRANT = 2'd1;
  localparam arb_state_t DGRANT = 2'd2;
  localparam arb_state_t DONE   = 2'd3;

  // Load value handed back when an access times out or the RAM errors
  localparam word_t BADWORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the instruction port, data port and RAM-side signals of the
// RAM arbiter. The arbiter uses the slave modport; the surrounding
// datapath/cache and RAM use the master modport.
interface ram_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore,
           memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore,
           memerr
  );

endinterface

// File: rtl/arb_timeout_cnt.sv
// Grant-length counter for the RAM arbiter: cleared outside a grant,
// counts every grant cycle and flags the last cycle allowed before abort.
module arb_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  // Count grant cycles; clear has priority so every grant starts at zero
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port RAM.
// Instruction fetch (read-only) and data access (read/write) share the RAM;
// a granted request is held on the RAM pins until ACCESS, ERROR or timeout,
// followed by a one-cycle DONE bubble with the RAM enables low.
// Optional: define RAM_ARB_RR_EN for round-robin arbitration between the
// two requesters; otherwise data always wins over instruction.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT = 64,
  parameter word_t BADWORD = BADWORD_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  ram_arbiter_if.slave  bus
);

  arb_state_t state;
  logic       in_grant;
  logic       access;
  logic       abort;
  logic       finish;
  logic       i_fin;
  logic       d_fin;
  logic       i_deliver;
  logic       d_deliver;
  logic       d_req;
  logic       pick_d;
  logic       pick_i;
  logic       tc;
  word_t      result;
  word_t      iload_q;
  word_t      dload_q;

  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (CLK),
    .rst    (RST),
    .clear  (!in_grant),
    .enable (in_grant),
    .tc     (tc)
  );

`ifdef RAM_ARB_RR_EN
  // High when the data port was granted most recently
  logic last_d;

  // Remember who was served last so simultaneous requests alternate
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_d <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_d) begin
        last_d <= 1'b1;
      end else if (pick_i) begin
        last_d <= 1'b0;
      end
    end
  end

  // On a tie, favour the requester that was not served last
  always_comb begin
    pick_d = d_req && (!bus.iREN || !last_d);
    pick_i = bus.iREN && !pick_d;
  end
`else
  // Fixed priority: data always beats instruction
  always_comb begin
    pick_d = d_req;
    pick_i = bus.iREN && !d_req;
  end
`endif

  // Completion decode; ACCESS wins over a coincident terminal count
  always_comb begin
    d_req     = bus.dREN || bus.dWEN;
    in_grant  = (state == IGRANT) || (state == DGRANT);
    access    = in_grant && (bus.ramstate == ACCESS);
    abort     = in_grant && !access && ((bus.ramstate == ERROR) || tc);
    finish    = access || abort;
    result    = abort ? BADWORD : bus.ramload;
    i_fin     = (state == IGRANT) && finish;
    d_fin     = (state == DGRANT) && finish;
    i_deliver = i_fin && bus.iREN;
    d_deliver = d_fin && d_req && (abort || !bus.ramWEN);
  end

  assign bus.iwait = bus.iREN && !i_fin;
  assign bus.dwait = d_req && !d_fin;
  assign bus.iload = i_deliver ? result : iload_q;
  assign bus.dload = d_deliver ? result : dload_q;

  // Main sequencer: latch the winning request onto the RAM pins, hold it
  // until the access completes, then drop everything for a DONE bubble
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
      bus.memerr   <= 1'b0;
      iload_q      <= '0;
      dload_q      <= '0;
    end else begin
      if (i_deliver) begin
        iload_q <= result;
      end
      if (d_deliver) begin
        dload_q <= result;
      end
      case (state)
        IDLE: begin
          if (pick_d) begin
            state        <= DGRANT;
            bus.ramaddr  <= bus.daddr;
            bus.ramstore <= bus.dstore;
            bus.ramWEN   <= bus.dWEN;
            bus.ramREN   <= bus.dREN && !bus.dWEN;
            if (bus.dREN && bus.dWEN) begin
              bus.memerr <= 1'b1;
            end
          end else if (pick_i) begin
            state        <= IGRANT;
            bus.ramaddr  <= bus.iaddr;
            bus.ramstore <= '0;
            bus.ramWEN   <= 1'b0;
            bus.ramREN   <= 1'b1;
          end
        end
        IGRANT, DGRANT: begin
          if (finish) begin
            state        <= DONE;
            bus.ramREN   <= 1'b0;
            bus.ramWEN   <= 1'b0;
            bus.ramaddr  <= '0;
            bus.ramstore <= '0;
            if (abort) begin
              bus.memerr <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small
// variable-latency RAM model (ACCESS in the 4th cycle of a grant).
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ram_arbiter_if bus ();

  ram_arbiter #(
    .TIMEOUT (8),
    .BADWORD (32'hBAD1BAD1)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // RAM model state
  word_t      mem [0:255];
  logic [3:0] ram_cnt;
  logic       ram_stuck;
  logic       ram_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency counter restarts whenever both enables are low; writes land on ACCESS
  always @(posedge clk) begin
    if (rst) begin
      mem[16] <= 32'h2402000A;
    end
    if (!(bus.ramREN || bus.ramWEN)) begin
      ram_cnt <= 4'd0;
    end else if (ram_cnt != 4'(LAT + 1)) begin
      ram_cnt <= ram_cnt + 4'd1;
    end
    if (bus.ramstate == ACCESS && bus.ramWEN) begin
      mem[bus.ramaddr[9:2]] <= bus.ramstore;
    end
  end

  // RAM status and read data
  always_comb begin
    bus.ramstate = FREE;
    bus.ramload  = 32'h0;
    if (bus.ramREN || bus.ramWEN) begin
      if (ram_err) begin
        bus.ramstate = ERROR;
      end else if (ram_stuck) begin
        bus.ramstate = BUSY;
      end else if (ram_cnt == 4'(LAT + 1)) begin
        bus.ramstate = ACCESS;
        bus.ramload  = mem[bus.ramaddr[9:2]];
      end else begin
        bus.ramstate = BUSY;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN   = 1'b0;
    bus.iaddr  = 32'h0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.daddr  = 32'h0;
    bus.dstore = 32'h0;
    ram_stuck  = 1'b0;
    ram_err    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.iREN = 1'b1;
    bus.dWEN = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL reset_ramREN: got %b expected 0", bus.ramREN); end
    checks++; if (bus.ramWEN !== 1'b0) begin errors++; $display("[TB] FAIL reset_ramWEN: got %b expected 0", bus.ramWEN); end
    checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_ramaddr: got %h expected 0", bus.ramaddr); end
    checks++; if (bus.ramstore !== 32'h0) begin errors++; $display("[TB] FAIL reset_ramstore: got %h expected 0", bus.ramstore); end
    checks++; if (bus.memerr !== 1'b0) begin errors++; $display("[TB] FAIL reset_memerr: got %b expected 0", bus.memerr); end
    checks++; if (bus.iload !== 32'h0) begin errors++; $display("[TB] FAIL reset_iload: got %h expected 0", bus.iload); end
    checks++; if (bus.dload !== 32'h0) begin errors++; $display("[TB] FAIL reset_dload: got %h expected 0", bus.dload); end
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL reset_iwait_follows: got %b expected 1", bus.iwait); end
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL reset_dwait_follows: got %b expected 1", bus.dwait); end
    clear_inputs();
    #1;
    checks++; if (bus.iwait !== 1'b0) begin errors++; $display("[TB] FAIL reset_iwait_low: got %b expected 0", bus.iwait); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ifetch();
    do_reset();
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    tick();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("[TB] FAIL ifetch_ramREN_gc1: got %b expected 1", bus.ramREN); end
    checks++; if (bus.ramaddr !== 32'h40) begin errors++; $display("[TB] FAIL ifetch_ramaddr: got %h expected 00000040", bus.ramaddr); end
    tick();
    tick();
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL ifetch_iwait_gc3: got %b expected 1", bus.iwait); end
    tick();
    checks++; if (bus.iwait !== 1'b0) begin errors++; $display("[TB] FAIL ifetch_iwait_gc4: got %b expected 0", bus.iwait); end
    checks++; if (bus.iload !== 32'h2402000A) begin errors++; $display("[TB] FAIL ifetch_iload_gc4: got %h expected 2402000a", bus.iload); end
    tick();
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL ifetch_ramREN_done: got %b expected 0", bus.ramREN); end
    checks++; if (bus.iload !== 32'h2402000A) begin errors++; $display("[TB] FAIL ifetch_iload_held: got %h expected 2402000a", bus.iload); end
    bus.iREN = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h40;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h80;
    bus.dstore = 32'hDEADBEEF;
    tick();
    checks++; if (bus.ramWEN !== 1'b1) begin errors++; $display("[TB] FAIL simul_ramWEN: got %b expected 1", bus.ramWEN); end
    checks++; if (bus.ramaddr !== 32'h80) begin errors++; $display("[TB] FAIL simul_ramaddr_d: got %h expected 00000080", bus.ramaddr); end
    checks++; if (bus.ramstore !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL simul_ramstore: got %h expected deadbeef", bus.ramstore); end
    tick();
    tick();
    tick();
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL simul_dwait_gc4: got %b expected 0", bus.dwait); end
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL simul_iwait_dgrant: got %b expected 1", bus.iwait); end
    tick();
    bus.dWEN = 1'b0;
    tick();
    checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL simul_idle_gap: got ramREN=%b iwait=%b expected ramREN=0 iwait=1", bus.ramREN, bus.iwait); end
    tick();
    checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin errors++; $display("[TB] FAIL simul_igrant: got ramREN=%b addr=%h expected ramREN=1 addr=00000040", bus.ramREN, bus.ramaddr); end
    tick();
    tick();
    checks++; if (bus.iwait !== 1'b1) begin errors++; $display("[TB] FAIL simul_iwait_gc3: got %b expected 1", bus.iwait); end
    tick();
    checks++; if (bus.iwait !== 1'b0 || bus.iload !== 32'h2402000A) begin errors++; $display("[TB] FAIL simul_iload: got iwait=%b iload=%h expected iwait=0 iload=2402000a", bus.iwait, bus.iload); end
    tick();
    bus.iREN = 1'b0;
    checks++; if (mem[32] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL simul_ram_write: got %h expected deadbeef", mem[32]); end
    tick();
  endtask

  task automatic test_priority();
    logic       grant_d [4];
    logic       exp_d   [4];
    logic       prev_en;
    logic       i_served;
    int         n;
    do_reset();
`ifdef RAM_ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h80;
    prev_en   = 1'b0;
    i_served  = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
      tick();
      if (bus.iwait === 1'b0) i_served = 1'b1;
      if (bus.ramREN === 1'b1 && !prev_en) begin
        grant_d[n] = (bus.ramaddr == 32'h80);
        n++;
      end
      prev_en = bus.ramREN;
    end
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL prio_grant_count: got %0d expected 4", n); end
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        checks++; if (grant_d[k] !== exp_d[k]) begin errors++; $display("[TB] FAIL prio_grant%0d_is_data: got %b expected %b", k, grant_d[k], exp_d[k]); end
      end
    end
`ifndef RAM_ARB_RR_EN
    checks++; if (i_served !== 1'b0) begin errors++; $display("[TB] FAIL prio_i_starved: got served=%b expected 0", i_served); end
`endif
    checks++; if (bus.dload !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL prio_dload: got %h expected deadbeef", bus.dload); end
    clear_inputs();
    tick();
    tick();
    tick();
    tick();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    ram_stuck = 1'b1;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h80;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (bus.dwait !== 1'b1 || bus.memerr !== 1'b0) begin errors++; $display("[TB] FAIL timeout_gc7: got dwait=%b memerr=%b expected dwait=1 memerr=0", bus.dwait, bus.memerr); end
    tick();
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL timeout_dwait_gc8: got %b expected 0", bus.dwait); end
    checks++; if (bus.dload !== 32'hBAD1BAD1) begin errors++; $display("[TB] FAIL timeout_dload: got %h expected bad1bad1", bus.dload); end
    tick();
    checks++; if (bus.memerr !== 1'b1) begin errors++; $display("[TB] FAIL timeout_memerr: got %b expected 1", bus.memerr); end
    bus.dREN  = 1'b0;
    ram_stuck = 1'b0;
    tick();
    tick();
    checks++; if (bus.memerr !== 1'b1) begin errors++; $display("[TB] FAIL timeout_memerr_sticky: got %b expected 1", bus.memerr); end
  endtask

  task automatic test_reset_mid_grant();
    checks++; if (bus.memerr !== 1'b1) begin errors++; $display("[TB] FAIL midrst_memerr_before: got %b expected 1", bus.memerr); end
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h40;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.ramREN !== 1'b0 || bus.memerr !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cleared: got ramREN=%b memerr=%b expected 0 0", bus.ramREN, bus.memerr); end
    rst = 1'b0;
    tick();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("[TB] FAIL midrst_regrant: got %b expected 1", bus.ramREN); end
    tick();
    tick();
    tick();
    checks++; if (bus.iwait !== 1'b0 || bus.iload !== 32'h2402000A) begin errors++; $display("[TB] FAIL midrst_service: got iwait=%b iload=%h expected iwait=0 iload=2402000a", bus.iwait, bus.iload); end
    tick();
    bus.iREN = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h84;
    bus.dstore = 32'h12345678;
    tick();
    checks++; if (bus.memerr !== 1'b1) begin errors++; $display("[TB] FAIL illegal_memerr: got %b expected 1", bus.memerr); end
    checks++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("[TB] FAIL illegal_as_write: got WEN=%b REN=%b expected WEN=1 REN=0", bus.ramWEN, bus.ramREN); end
    tick();
    tick();
    checks++; if (bus.dwait !== 1'b1) begin errors++; $display("[TB] FAIL illegal_dwait_gc3: got %b expected 1", bus.dwait); end
    tick();
    checks++; if (bus.dwait !== 1'b0) begin errors++; $display("[TB] FAIL illegal_dwait_gc4: got %b expected 0", bus.dwait); end
    tick();
    clear_inputs();
    checks++; if (mem[33] !== 32'h12345678) begin errors++; $display("[TB] FAIL illegal_write: got %h expected 12345678", mem[33]); end
    tick();
  endtask

  task automatic test_ram_error();
    do_reset();
    ram_err   = 1'b1;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h80;
    tick();
    checks++; if (bus.dwait !== 1'b0 || bus.dload !== 32'hBAD1BAD1) begin errors++; $display("[TB] FAIL ramerr_abort: got dwait=%b dload=%h expected dwait=0 dload=bad1bad1", bus.dwait, bus.dload); end
    tick();
    checks++; if (bus.memerr !== 1'b1) begin errors++; $display("[TB] FAIL ramerr_memerr: got %b expected 1", bus.memerr); end
    clear_inputs();
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ifetch();
    test_simultaneous();
    test_priority();
    test_timeout();
    test_reset_mid_grant();
    test_illegal();
    test_ram_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
